// File: rtl/red_fetch_decode_if.sv
// Instruction-memory request/response port of the reduced fetch/decode sequencer.
// The sequencer is the master (drives req/addr); the memory is the slave (returns rdata/rvalid).
interface red_fetch_decode_if #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  req;
    logic [PC_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output rvalid
    );
endinterface

// File: rtl/red_fetch_decode.sv
// red_fetch_decode: owns the PC, fetches RV32I words and drives the reduced datapath for ADDI/ADD/SUB/BNE.
// Optional build macro RED_ILLEGAL_TRAP_EN: unsupported words halt the core instead of retiring as NOPs.
module red_fetch_decode #(
    parameter int                  ADDRESS_WIDTH = 5,
    parameter int                  ALUctrl_WIDTH = 3,
    parameter int                  DATA_WIDTH    = 32,
    parameter int                  PC_WIDTH      = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    red_fetch_decode_if.master       imem,
    input  logic                     EQ,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    output logic                     ALUsrc,
    output logic [ALUctrl_WIDTH-1:0] ALUctrl,
    output logic                     RegWrite,
    output logic [PC_WIDTH-1:0]      pc,
    output logic                     retire,
    output logic                     halted
);
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [ALUctrl_WIDTH-1:0] ALU_ADD = ALUctrl_WIDTH'(0);
    localparam logic [ALUctrl_WIDTH-1:0] ALU_SUB = ALUctrl_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  is_addi, is_add, is_sub, is_bne;
    logic [DATA_WIDTH-1:0] imm_i, imm_b;
    logic                  in_exec;
    logic                  branch_taken;
    logic [PC_WIDTH-1:0]   pc_next;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    assign is_addi = (opcode == OP_IMM) && (funct3 == 3'b000);
    assign is_add  = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_sub  = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    assign is_bne  = (opcode == OP_BRANCH) && (funct3 == 3'b001);

`ifdef RED_ILLEGAL_TRAP_EN
    logic legal;
    assign legal = is_addi || is_add || is_sub || is_bne;
`endif

    assign imm_i = {{(DATA_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_b = {{(DATA_WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

    // EQ only matters in EXEC; the PC adder wraps silently modulo 2^PC_WIDTH.
    assign in_exec      = (state_q == S_EXEC);
    assign branch_taken = is_bne && !EQ;
    assign pc_next      = branch_taken ? (pc_q + PC_WIDTH'(imm_b)) : (pc_q + PC_WIDTH'(4));

    assign imem.req  = (state_q == S_FETCH);
    assign imem.addr = pc_q;

    assign rs1 = ADDRESS_WIDTH'(ir_q[19:15]);
    assign rs2 = ADDRESS_WIDTH'(ir_q[24:20]);
    assign rd  = ADDRESS_WIDTH'(ir_q[11:7]);
    assign pc  = pc_q;

`ifdef RED_ILLEGAL_TRAP_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem.rvalid) begin
                    ir_d    = imem.rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_d    = pc_next;
                state_d = run ? S_FETCH : S_IDLE;
`ifdef RED_ILLEGAL_TRAP_EN
                if (!legal) begin
                    pc_d    = pc_q;
                    state_d = S_HALT;
                end
`endif
            end
            S_HALT: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_comb begin
        ALUsrc   = 1'b0;
        ALUctrl  = ALU_ADD;
        RegWrite = 1'b0;
        ImmOp    = '0;
        retire   = 1'b0;
        if (in_exec) begin
            if (is_addi) begin
                ALUsrc   = 1'b1;
                RegWrite = 1'b1;
                ImmOp    = imm_i;
            end else if (is_add) begin
                RegWrite = 1'b1;
            end else if (is_sub) begin
                ALUctrl  = ALU_SUB;
                RegWrite = 1'b1;
            end else if (is_bne) begin
                ALUctrl  = ALU_SUB;
                ImmOp    = imm_b;
            end
`ifdef RED_ILLEGAL_TRAP_EN
            retire = legal;
`else
            retire = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end
endmodule

// File: tb/tb_red_fetch_decode.sv
// Self-checking bench for red_fetch_decode: directed vector table, hand-written reset/run sequences,
// and random instructions checked against a field-extraction reference model.
module tb_red_fetch_decode;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        EQ;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] ImmOp;
    logic        ALUsrc;
    logic [2:0]  ALUctrl;
    logic        RegWrite;
    logic [31:0] pc;
    logic        retire;
    logic        halted;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pc;

    typedef struct {
        logic [31:0] word;
        logic        eq;
        int          waits;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        chk_imm;
        logic        alusrc;
        logic [2:0]  aluctrl;
        logic        regwrite;
        logic        retire;
        logic [31:0] delta;
    } vec_t;

    red_fetch_decode_if #(.PC_WIDTH(32), .DATA_WIDTH(32)) imem_if ();

    red_fetch_decode #(
        .ADDRESS_WIDTH(5),
        .ALUctrl_WIDTH(3),
        .DATA_WIDTH(32),
        .PC_WIDTH(32),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .imem(imem_if),
        .EQ(EQ),
        .rs1(rs1),
        .rs2(rs2),
        .rd(rd),
        .ImmOp(ImmOp),
        .ALUsrc(ALUsrc),
        .ALUctrl(ALUctrl),
        .RegWrite(RegWrite),
        .pc(pc),
        .retire(retire),
        .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference decode straight from the RV32I field rules, using shifts and masks on the word.
    function automatic vec_t modelVector(input logic [31:0] word, input logic eq);
        vec_t        v;
        logic [31:0] op, f3, f7, b;
        op = word & 32'h7f;
        f3 = (word >> 12) & 32'h7;
        f7 = word >> 25;
        v.word     = word;
        v.eq       = eq;
        v.waits    = 0;
        v.rd       = 5'((word >> 7) & 32'h1f);
        v.rs1      = 5'((word >> 15) & 32'h1f);
        v.rs2      = 5'((word >> 20) & 32'h1f);
        v.imm      = 32'h0;
        v.chk_imm  = 1'b0;
        v.alusrc   = 1'b0;
        v.aluctrl  = 3'd0;
        v.regwrite = 1'b0;
        v.retire   = 1'b1;
        v.delta    = 32'd4;
        if (op == 32'h13 && f3 == 32'h0) begin
            v.alusrc   = 1'b1;
            v.regwrite = 1'b1;
            v.chk_imm  = 1'b1;
            v.imm      = 32'($signed(word) >>> 20);
        end else if (op == 32'h33 && f3 == 32'h0 && f7 == 32'h0) begin
            v.regwrite = 1'b1;
        end else if (op == 32'h33 && f3 == 32'h0 && f7 == 32'h20) begin
            v.regwrite = 1'b1;
            v.aluctrl  = 3'd1;
        end else if (op == 32'h63 && f3 == 32'h1) begin
            b = (((word >> 31) & 32'h1) << 12) | (((word >> 7) & 32'h1) << 11)
              | (((word >> 25) & 32'h3f) << 5) | (((word >> 8) & 32'hf) << 1);
            if (b >= 32'd4096) b = b - 32'd8192;
            v.aluctrl = 3'd1;
            v.chk_imm = 1'b1;
            v.imm     = b;
            if (!eq) v.delta = b;
        end else begin
`ifdef RED_ILLEGAL_TRAP_EN
            v.retire = 1'b0;
            v.delta  = 32'd0;
`endif
        end
        return v;
    endfunction

    // Entered at a falling edge with the DUT in FETCH; leaves at the falling edge after EXEC.
    task automatic applyStimulus(input vec_t v);
        checkOutput("fetch_req", 32'(imem_if.req), 32'd1);
        checkOutput("fetch_addr", imem_if.addr, exp_pc);
        for (int w = 0; w < v.waits; w++) begin
            imem_if.rvalid = 1'b0;
            @(negedge clk);
            checkOutput("wait_req", 32'(imem_if.req), 32'd1);
            checkOutput("wait_addr", imem_if.addr, exp_pc);
            checkOutput("wait_regwrite", 32'(RegWrite), 32'd0);
        end
        imem_if.rvalid = 1'b1;
        imem_if.rdata  = v.word;
        EQ             = v.eq;
        @(negedge clk);
        imem_if.rvalid = 1'b0;
        imem_if.rdata  = $urandom;
        checkOutput("exec_req", 32'(imem_if.req), 32'd0);
        checkOutput("exec_rd", 32'(rd), 32'(v.rd));
        checkOutput("exec_rs1", 32'(rs1), 32'(v.rs1));
        checkOutput("exec_rs2", 32'(rs2), 32'(v.rs2));
        checkOutput("exec_alusrc", 32'(ALUsrc), 32'(v.alusrc));
        checkOutput("exec_aluctrl", 32'(ALUctrl), 32'(v.aluctrl));
        checkOutput("exec_regwrite", 32'(RegWrite), 32'(v.regwrite));
        checkOutput("exec_retire", 32'(retire), 32'(v.retire));
        if (v.chk_imm) checkOutput("exec_immop", ImmOp, v.imm);
        @(negedge clk);
        exp_pc = exp_pc + v.delta;
        checkOutput("post_pc", pc, exp_pc);
        checkOutput("post_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("post_retire", 32'(retire), 32'd0);
    endtask

    initial begin
        vec_t        vecs[12];
        vec_t        v;
        int          n_tbl;
        int          max_kind;
        int          kind;
        logic [31:0] word;
        logic [4:0]  r_rd, r_rs1, r_rs2;
        logic [11:0] r_imm;
        logic [12:0] r_b;

`ifdef RED_ILLEGAL_TRAP_EN
        n_tbl    = 10;
        max_kind = 3;
`else
        n_tbl    = 12;
        max_kind = 4;
`endif
        //          word          eq    wt rd     rs1    rs2    imm            chk   src   ctrl  rw    ret   delta
        vecs[0]  = '{32'h00500093, 1'b0, 0, 5'd1,  5'd0,  5'd5,  32'd5,        1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 32'd4};
        vecs[1]  = '{32'h40208133, 1'b0, 0, 5'd2,  5'd1,  5'd2,  32'd0,        1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'd4};
        vecs[2]  = '{32'h002081B3, 1'b1, 1, 5'd3,  5'd1,  5'd2,  32'd0,        1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 32'd4};
        vecs[3]  = '{32'h00000013, 1'b0, 0, 5'd0,  5'd0,  5'd0,  32'd0,        1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 32'd4};
        vecs[4]  = '{32'hFE209CE3, 1'b0, 0, 5'd25, 5'd1,  5'd2,  32'hFFFFFFF8, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 32'hFFFFFFF8};
        vecs[5]  = '{32'hFFF30293, 1'b0, 2, 5'd5,  5'd6,  5'd31, 32'hFFFFFFFF, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 32'd4};
        vecs[6]  = '{32'h002081B3, 1'b0, 0, 5'd3,  5'd1,  5'd2,  32'd0,        1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 32'd4};
        vecs[7]  = '{32'hFE209CE3, 1'b1, 0, 5'd25, 5'd1,  5'd2,  32'hFFFFFFF8, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 32'd4};
        vecs[8]  = '{32'h00419863, 1'b0, 0, 5'd16, 5'd3,  5'd4,  32'd16,       1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 32'd16};
        vecs[9]  = '{32'h80001063, 1'b0, 0, 5'd0,  5'd0,  5'd0,  32'hFFFFF000, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 32'hFFFFF000};
        vecs[10] = '{32'hFFFFFFFF, 1'b0, 0, 5'd31, 5'd31, 5'd31, 32'd0,        1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 32'd4};
        vecs[11] = '{32'h002091B3, 1'b0, 0, 5'd3,  5'd1,  5'd2,  32'd0,        1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 32'd4};

        rst_n          = 1'b0;
        run            = 1'b0;
        EQ             = 1'b0;
        imem_if.rvalid = 1'b0;
        imem_if.rdata  = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_req", 32'(imem_if.req), 32'd0);
        checkOutput("reset_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("reset_alusrc", 32'(ALUsrc), 32'd0);
        checkOutput("reset_aluctrl", 32'(ALUctrl), 32'd0);
        checkOutput("reset_immop", ImmOp, 32'd0);
        checkOutput("reset_retire", 32'(retire), 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        checkOutput("reset_rd", 32'(rd), 32'd0);
        checkOutput("reset_rs1", 32'(rs1), 32'd0);

        rst_n  = 1'b1;
        exp_pc = 32'h0;
        @(negedge clk);
        checkOutput("idle_no_run_req", 32'(imem_if.req), 32'd0);
        run = 1'b1;
        @(negedge clk);

        for (int i = 0; i < n_tbl; i++) begin
            applyStimulus(vecs[i]);
        end

        // run dropped mid-FETCH: fetch and EXEC still complete, then IDLE ignores rvalid.
        run     = 1'b0;
        v       = modelVector(32'h00300393, 1'b0);
        v.waits = 1;
        applyStimulus(v);
        checkOutput("stop_idle_req", 32'(imem_if.req), 32'd0);
        imem_if.rvalid = 1'b1;
        imem_if.rdata  = 32'h00500093;
        @(negedge clk);
        imem_if.rvalid = 1'b0;
        checkOutput("idle_rvalid_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("idle_rvalid_rd", 32'(rd), 32'd7);
        checkOutput("idle_rvalid_req", 32'(imem_if.req), 32'd0);
        checkOutput("idle_rvalid_pc", pc, exp_pc);
        run = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a FETCH wait.
        checkOutput("pre_reset_req", 32'(imem_if.req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_req", 32'(imem_if.req), 32'd0);
        checkOutput("async_reset_pc", pc, 32'h0);
        checkOutput("async_reset_regwrite", 32'(RegWrite), 32'd0);
        @(negedge clk);
        run    = 1'b0;
        rst_n  = 1'b1;
        exp_pc = 32'h0;
        @(negedge clk);
        imem_if.rvalid = 1'b1;
        imem_if.rdata  = 32'h00500093;
        @(negedge clk);
        imem_if.rvalid = 1'b0;
        checkOutput("late_rvalid_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("late_rvalid_req", 32'(imem_if.req), 32'd0);
        checkOutput("late_rvalid_rd", 32'(rd), 32'd0);
        checkOutput("late_rvalid_pc", pc, 32'h0);
        run = 1'b1;
        @(negedge clk);

        // Asynchronous reset during EXEC kills the write pulse.
        applyStimulus(modelVector(32'h00500093, 1'b0));
        checkOutput("exec_reset_pre_req", 32'(imem_if.req), 32'd1);
        imem_if.rvalid = 1'b1;
        imem_if.rdata  = 32'h00A00113;
        @(negedge clk);
        imem_if.rvalid = 1'b0;
        checkOutput("exec_reset_pre_regwrite", 32'(RegWrite), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("exec_reset_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("exec_reset_retire", 32'(retire), 32'd0);
        checkOutput("exec_reset_pc", pc, 32'h0);
        checkOutput("exec_reset_rd", 32'(rd), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'h0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            kind  = int'($urandom_range(0, max_kind));
            r_rd  = 5'($urandom);
            r_rs1 = 5'($urandom);
            r_rs2 = 5'($urandom);
            r_imm = 12'($urandom);
            r_b   = 13'($urandom);
            r_b[0] = 1'b0;
            case (kind)
                0:       word = {r_imm, r_rs1, 3'b000, r_rd, 7'b0010011};
                1:       word = {7'b0000000, r_rs2, r_rs1, 3'b000, r_rd, 7'b0110011};
                2:       word = {7'b0100000, r_rs2, r_rs1, 3'b000, r_rd, 7'b0110011};
                3:       word = {r_b[12], r_b[10:5], r_rs2, r_rs1, 3'b001, r_b[4:1], r_b[11], 7'b1100011};
                default: word = $urandom;
            endcase
            v       = modelVector(word, 1'($urandom_range(0, 1)));
            v.waits = int'($urandom_range(0, 2));
            applyStimulus(v);
        end

`ifdef RED_ILLEGAL_TRAP_EN
        imem_if.rvalid = 1'b1;
        imem_if.rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        imem_if.rvalid = 1'b0;
        checkOutput("trap_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("trap_retire", 32'(retire), 32'd0);
        @(negedge clk);
        checkOutput("trap_halted", 32'(halted), 32'd1);
        checkOutput("trap_pc", pc, exp_pc);
        for (int k = 0; k < 3; k++) begin
            checkOutput("trap_no_req", 32'(imem_if.req), 32'd0);
            @(negedge clk);
        end
        checkOutput("trap_still_halted", 32'(halted), 32'd1);
`else
        applyStimulus(modelVector(32'hFFFFFFFF, 1'b0));
        checkOutput("nop_halted", 32'(halted), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
